micro_sequencer: RTL

Microprogram sequencer for each core's control unit. It holds the micro-program counter (uPC) that addresses the microcode control store. It steps, branches and halts according to the next-address field of the current microword. On a dispatch microword it loads the uPC from the opcode-to-microaddress mapping output, which makes it the consumer end of that mapping interface. It also handles core start/done signalling to the top-level scheduler.

---
 rtl/micro_pkg.sv | 27 ++
 rtl/micro_next_addr.sv | 59 +++++
 rtl/micro_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing-field
// encodings, default widths/addresses and the sequencer state encoding.
package micro_pkg;

    localparam int UPC_W_DEF      = 8;
    localparam int FETCH_ADDR_DEF = 0;

    // Sequencing field of a microword
    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_BRZ      = 3'd2,
        SEQ_BRNZ     = 3'd3,
        SEQ_DISPATCH = 3'd4,
        SEQ_FETCH    = 3'd5,
        SEQ_HALT     = 3'd6,
        SEQ_RSVD     = 3'd7
    } seq_op_e;

    // Sequencer control state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/micro_next_addr.sv
// Combinational next-microaddress mux with control-store range check.
// illegal flags a dispatch target or sequential/branch target that lies
// outside the populated control store.
module micro_next_addr
    import micro_pkg::*;
#(
    parameter int UPC_W      = UPC_W_DEF,
    parameter int DEPTH      = 75,
    parameter int FETCH_ADDR = FETCH_ADDR_DEF
) (
    input  logic [UPC_W-1:0] upc,
    input  logic [2:0]       uop,
    input  logic [UPC_W-1:0] ubr,
    input  logic             z_flag,
    input  logic [15:0]      map_addr,
    output logic [UPC_W-1:0] nxt_upc,
    output logic             illegal
);

    localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_ADDR);
    // One extra bit so upc+1 wrapping past the top of the field is still caught
    localparam logic [UPC_W:0]   DEPTH_W   = (UPC_W+1)'(DEPTH);
    localparam logic [15:0]      DEPTH_16  = 16'(DEPTH);

    logic [UPC_W:0] inc_wide;
    logic [UPC_W:0] tgt_wide;
    logic           seq_tgt;

    assign inc_wide = {1'b0, upc} + {{UPC_W{1'b0}}, 1'b1};

    // Select the next address; sequential/branch targets share one range check
    always_comb begin
        tgt_wide = inc_wide;
        seq_tgt  = 1'b1;
        nxt_upc  = inc_wide[UPC_W-1:0];
        illegal  = 1'b0;
        case (uop)
            SEQ_JUMP: tgt_wide = {1'b0, ubr};
            SEQ_BRZ:  if (z_flag)  tgt_wide = {1'b0, ubr};
            SEQ_BRNZ: if (!z_flag) tgt_wide = {1'b0, ubr};
            SEQ_DISPATCH: begin
                seq_tgt = 1'b0;
                nxt_upc = map_addr[UPC_W-1:0];
                // Full-width compare: high map bits beyond UPC_W are not ignored
                illegal = (map_addr >= DEPTH_16);
            end
            SEQ_FETCH, SEQ_HALT: begin
                seq_tgt = 1'b0;
                nxt_upc = FETCH_UPC;
            end
            default: tgt_wide = inc_wide;  // NEXT and reserved
        endcase
        if (seq_tgt) begin
            nxt_upc = tgt_wide[UPC_W-1:0];
            illegal = (tgt_wide >= DEPTH_W);
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: uPC register, IDLE/RUN/ERR control, done pulse
// and dispatched-instruction counter. Next address comes from micro_next_addr.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int UPC_W      = UPC_W_DEF,
    parameter int DEPTH      = 75,
    parameter int FETCH_ADDR = FETCH_ADDR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      map_addr,
    input  logic [2:0]       uop,
    input  logic [UPC_W-1:0] ubr,
    input  logic             z_flag,
    input  logic             stall,
    output logic [UPC_W-1:0] upc,
    output logic             run,
    output logic             done,
    output logic             err,
    output logic [15:0]      instr_cnt
);

    localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_ADDR);

    seq_state_e       state_reg, state_next;
    logic [UPC_W-1:0] upc_reg, upc_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [15:0]      cnt_reg, cnt_next;

    logic [UPC_W-1:0] nxt_upc;
    logic             illegal;

    micro_next_addr #(
        .UPC_W      (UPC_W),
        .DEPTH      (DEPTH),
        .FETCH_ADDR (FETCH_ADDR)
    ) u_next_addr (
        .upc      (upc_reg),
        .uop      (uop),
        .ubr      (ubr),
        .z_flag   (z_flag),
        .map_addr (map_addr),
        .nxt_upc  (nxt_upc),
        .illegal  (illegal)
    );

    // State, uPC, done pulse, error flag and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            upc_reg   <= FETCH_UPC;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= 16'd0;
        end else begin
            state_reg <= state_next;
            upc_reg   <= upc_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; stall freezes everything, done defaults low so it pulses
    always_comb begin
        state_next = state_reg;
        upc_next   = upc_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    upc_next   = FETCH_UPC;
                    cnt_next   = 16'd0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (illegal) begin
                        // uPC is left pointing at the offending microword
                        state_next = ST_ERR;
                        err_next   = 1'b1;
                    end else if (uop == SEQ_HALT) begin
                        state_next = ST_IDLE;
                        upc_next   = FETCH_UPC;
                        done_next  = 1'b1;
                    end else begin
                        upc_next = nxt_upc;
                        if (uop == SEQ_DISPATCH) begin
                            cnt_next = cnt_reg + 16'd1;
                        end
                    end
                end
            end
            ST_ERR: begin
                if (start) begin
                    state_next = ST_RUN;
                    upc_next   = FETCH_UPC;
                    cnt_next   = 16'd0;
                    err_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                upc_next   = FETCH_UPC;
            end
        endcase
    end

    assign upc       = upc_reg;
    assign run       = (state_reg == ST_RUN);
    assign done      = done_reg;
    assign err       = err_reg;
    assign instr_cnt = cnt_reg;

endmodule
